mem_io_bridge: RTL

- Sits directly downstream of the CPU's memory port, between the CPU and the 256x16 synchronous RAM.
- Decodes the CPU's 8-bit address. Addresses 0x00–0xFB go to RAM; the top four words are memory-mapped I/O: switch status, switch data, LED register and a cycle counter.
- Returns read data with the same one-cycle latency as the RAM, so CPU load sequences are unchanged.

---
 rtl/mem_io_pkg.sv | 14 +
 rtl/sw_sync.sv | 32 +++
 rtl/mem_io_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared definitions for the CPU memory/I-O bridge: I/O register offsets and
// the default I/O window base.
package mem_io_pkg;

  typedef enum logic [1:0] {
    IO_SW_STATUS = 2'd0,
    IO_SW_DATA   = 2'd1,
    IO_LED       = 2'd2,
    IO_TICK      = 2'd3
  } io_reg_e;

  localparam logic [7:0] IO_BASE_DEFAULT = 8'hFC;

endpackage

// File: rtl/sw_sync.sv
// Slide-switch synchronizer: two-flop metastability guard, then change
// detection against the previous synchronized value.
module sw_sync #(
  parameter int unsigned W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] sw_data_o,
  output logic         change_o
);

  logic [W-1:0] s1_q, s2_q, prev_q, data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      data_q <= '0;
    end else begin
      s1_q   <= sw_i;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      if (s2_q != prev_q) data_q <= s2_q;
    end
  end

  assign change_o  = (s2_q != prev_q);
  assign sw_data_o = data_q;

endmodule

// File: rtl/mem_io_bridge.sv
// Address decoder between the CPU memory port and the 256x16 RAM; the top
// four words are memory-mapped switch, LED and cycle-counter registers.
module mem_io_bridge
  import mem_io_pkg::*;
#(
  parameter int unsigned SW_WIDTH  = 10,
  parameter int unsigned LED_WIDTH = 10,
  parameter logic [7:0]  IO_BASE   = IO_BASE_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           cpu_addr,
  input  logic                 cpu_w_en,
  input  logic [15:0]          cpu_w_data,
  output logic [15:0]          cpu_r_data,
  output logic [7:0]           ram_addr,
  output logic                 ram_w_en,
  output logic [15:0]          ram_w_data,
  input  logic [15:0]          ram_r_data,
  input  logic [SW_WIDTH-1:0]  sw,
  output logic [LED_WIDTH-1:0] ledr
);

  logic                 is_io;
  logic [7:0]           io_off;
  io_reg_e              io_sel;
  logic                 io_wr;

  logic [SW_WIDTH-1:0]  sw_data;
  logic                 sw_change;

  logic                 pending_q, pending_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [15:0]          tick_q, tick_d;
  logic                 rd_io_q, rd_io_d;
  logic [15:0]          rd_val_q, rd_val_d;

  assign is_io  = (cpu_addr >= IO_BASE);
  assign io_off = cpu_addr - IO_BASE;
  assign io_sel = io_reg_e'(io_off[1:0]);
  assign io_wr  = cpu_w_en & is_io;

  assign ram_addr   = cpu_addr;
  assign ram_w_data = cpu_w_data;
  assign ram_w_en   = cpu_w_en & ~is_io;

  sw_sync #(.W(SW_WIDTH)) u_sw_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .sw_i     (sw),
    .sw_data_o(sw_data),
    .change_o (sw_change)
  );

  always_comb begin
    pending_d = pending_q;
    led_d     = led_q;
    tick_d    = tick_q + 16'd1;
    rd_io_d   = is_io;
    rd_val_d  = '0;

    if (io_wr) begin
      unique case (io_sel)
        IO_SW_STATUS: if (cpu_w_data[0]) pending_d = 1'b0;
        IO_SW_DATA:   ;
        IO_LED:       led_d  = cpu_w_data[LED_WIDTH-1:0];
        IO_TICK:      tick_d = cpu_w_data;
      endcase
    end
    // A change landing in the same cycle as a W1C clear must not be lost.
    if (sw_change) pending_d = 1'b1;

    // TICK reads capture the value the counter takes at the registering edge.
    if (is_io) begin
      unique case (io_sel)
        IO_SW_STATUS: rd_val_d = {15'b0, pending_q};
        IO_SW_DATA:   rd_val_d = 16'(sw_data);
        IO_LED:       rd_val_d = 16'(led_q);
        IO_TICK:      rd_val_d = tick_d;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      led_q     <= '0;
      tick_q    <= '0;
      rd_io_q   <= 1'b0;
      rd_val_q  <= '0;
    end else begin
      pending_q <= pending_d;
      led_q     <= led_d;
      tick_q    <= tick_d;
      rd_io_q   <= rd_io_d;
      rd_val_q  <= rd_val_d;
    end
  end

  assign cpu_r_data = rd_io_q ? rd_val_q : ram_r_data;
  assign ledr       = led_q;

endmodule
